// File: rtl/led_switch_io.sv
// LED bank writer and debounced switch reader on the CPU memory-mapped IO path.
// Define LED_READBACK_EN to let SwitchCtrl reads at the LED addresses return the LED bank.
module led_switch_io #(
  parameter int                 CNT_W           = 20,
  parameter logic [CNT_W-1:0]   DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] io_addr,
  input  logic        LEDCtrl,
  input  logic        SwitchCtrl,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  output logic [23:0] led,
  input  logic [23:0] switch_in
);

  localparam logic [31:0] A_LED_LO = 32'hFFFF_FC60;
  localparam logic [31:0] A_LED_HI = 32'hFFFF_FC62;
  localparam logic [31:0] A_SW_LO  = 32'hFFFF_FC70;
  localparam logic [31:0] A_SW_HI  = 32'hFFFF_FC72;

  localparam logic [CNT_W-1:0] TICK_AT = DEBOUNCE_CYCLES - CNT_W'(1);

  logic [23:0]      led_q,    led_d;
  logic [23:0]      sync1_q;
  logic [23:0]      sync2_q;
  logic [23:0]      sample_q, sample_d;
  logic [23:0]      deb_q,    deb_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic tick;
  logic wr_lo;
  logic wr_hi;
  logic rd_sw_lo;
  logic rd_sw_hi;
  logic rd_led_lo;
  logic rd_led_hi;

  assign tick  = (cnt_q == TICK_AT);
  assign wr_lo = LEDCtrl && (io_addr == A_LED_LO);
  assign wr_hi = LEDCtrl && (io_addr == A_LED_HI);

  assign rd_sw_lo  = SwitchCtrl && (io_addr == A_SW_LO);
  assign rd_sw_hi  = SwitchCtrl && (io_addr == A_SW_HI);
  assign rd_led_lo = SwitchCtrl && (io_addr == A_LED_LO);
  assign rd_led_hi = SwitchCtrl && (io_addr == A_LED_HI);

  always_comb begin
    led_d = led_q;
    if (wr_lo) led_d[15:0]  = io_wdata;
    if (wr_hi) led_d[23:16] = io_wdata[7:0];
  end

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Qualify only when two consecutive tick samples agree on the whole vector.
  always_comb begin
    sample_d = sample_q;
    deb_d    = deb_q;
    if (tick) begin
      sample_d = sync2_q;
      if (sync2_q == sample_q) deb_d = sync2_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      sample_q <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
    end else begin
      led_q    <= led_d;
      sync1_q  <= switch_in;
      sync2_q  <= sync1_q;
      sample_q <= sample_d;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    io_rdata = 16'h0000;
    unique case (1'b1)
      rd_sw_lo:  io_rdata = deb_q[15:0];
      rd_sw_hi:  io_rdata = {8'h00, deb_q[23:16]};
`ifdef LED_READBACK_EN
      rd_led_lo: io_rdata = led_q[15:0];
      rd_led_hi: io_rdata = {8'h00, led_q[23:16]};
`else
      rd_led_lo: io_rdata = 16'h0000;
      rd_led_hi: io_rdata = 16'h0000;
`endif
      default:   io_rdata = 16'h0000;
    endcase
  end

  assign led = led_q;

endmodule

// File: doc/led_switch_io.md
Name: led_switch_io

Overview:
- Peripheral-side responder for the CPU's memory-mapped IO path.
- Accepts IO writes and drives the board LEDs through a registered 24-bit LED bank.
- Serves IO reads with a synchronised, debounced 24-bit switch bank, returned 16 bits at a time.
- Sits between the CPU's IO chip selects (LEDCtrl, SwitchCtrl) plus address/write data, and the board pins.

Parameters:
- DEBOUNCE_CYCLES, 20'd500000: clock cycles between switch samples; must be >= 1.
- CNT_W, 20: width of the sample-tick counter.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- io_addr  input  32  byte address from the ALU result.
- LEDCtrl  input  1  LED chip select; a write request while high.
- SwitchCtrl  input  1  switch chip select; a read request while high.
- io_wdata  input  16  write data; low 16 bits of the register operand.
- io_rdata  output  16  read data returned to the CPU.
- led  output  24  LED pins; bit 0 = LED0.
- switch_in  input  24  raw, asynchronous switch pins.

Behaviour:
- Address map; only io_addr[31:0] exact matches are decoded:
  - 0xFFFFFC60 = LED[15:0]
  - 0xFFFFFC62 = LED[23:16] (write data bits [7:0])
  - 0xFFFFFC70 = SW[15:0]
  - 0xFFFFFC72 = SW[23:16], zero-extended to 16 bits
- Reset (reset_n low, asynchronous): the following clear to 0 and hold while reset is low:
  - led, both synchroniser stages, the sample register, the debounced register and the tick counter.
  - io_rdata is 0 during reset (it is combinational from cleared state).
- LED write:
  - On the rising edge with LEDCtrl=1 and address 0xFFFFFC60, led[15:0] <= io_wdata.
  - With address 0xFFFFFC62, led[23:16] <= io_wdata[7:0].
  - Other LED bits hold. led is visible one cycle after the edge.
  - LEDCtrl=1 with a non-LED address: no state change.
- Switch path:
  - Two-flop synchroniser sync1 <= switch_in, sync2 <= sync1.
  - Tick counter counts 0..DEBOUNCE_CYCLES-1 and wraps. tick = (count == DEBOUNCE_CYCLES-1).
  - With DEBOUNCE_CYCLES=1, tick is high every cycle.
  - On tick: sample <= sync2. If sync2 == sample (the two consecutive tick samples agree), then debounced <= sync2.
  - Comparison and update are whole-vector (all 24 bits agree), not per bit.
  - A pin change reaches debounced after 2 sync cycles plus 2 ticks worst case.
  - A glitch shorter than one tick period never reaches debounced.
- Switch read (combinational, same cycle):
  - SwitchCtrl=1 and address 0xFFFFFC70 -> io_rdata = debounced[15:0].
  - SwitchCtrl=1 and address 0xFFFFFC72 -> io_rdata = {8'h00, debounced[23:16]}.
  - Any other case -> io_rdata = 16'h0000. Never high-Z.
- LEDCtrl and SwitchCtrl both high: the write commits at the edge. The read returns pre-edge state.
- Reset mid-debounce: the partial count and samples are discarded. The debounced value re-qualifies from 0 after reset release.

Optional Feature:
- Macro LED_READBACK_EN.
- Defined: SwitchCtrl=1 at 0xFFFFFC60 returns led[15:0]; at 0xFFFFFC62 returns {8'h00, led[23:16]}.
- Undefined: those reads return 16'h0000.
- LED write behaviour is identical in both builds.

Test Plan:
- Reset: hold reset_n=0 with switch_in=24'hFFFFFF for 10 cycles -> led=0; SwitchCtrl read at 0xFFFFFC70 returns 16'h0000.
- LED write: with reset released, LEDCtrl=1, addr 0xFFFFFC60, wdata 16'hA5C3 for 1 cycle, then addr 0xFFFFFC62, wdata 16'h1234 -> led=24'h34A5C3 one cycle after each edge. LEDCtrl=1 at 0xFFFFFC64 -> led unchanged.
- Debounce (DEBOUNCE_CYCLES=4):
  - switch_in=24'h00BEEF held -> read at 0xFFFFFC70 returns 16'hBEEF within 2+8 cycles, and 0 before the first qualifying tick pair.
  - A 2-cycle pulse on switch_in[0] between ticks -> debounced unchanged.
- High-half read: switch_in=24'h7F0000 settled -> read at 0xFFFFFC72 returns 16'h007F. Read at 0xFFFFFC74 returns 16'h0000.
- Simultaneous access: LEDCtrl=1 and SwitchCtrl=1 at 0xFFFFFC60 with wdata 16'h00FF, led previously 0:
  - LED_READBACK_EN defined -> io_rdata=16'h0000 in that cycle, 16'h00FF in the next read.
  - Undefined -> io_rdata 16'h0000 in both.
- Reset mid-operation: assert reset_n=0 for 1 cycle at count=2 with debounced=24'h00BEEF -> led=0 and debounced=0 immediately. After release, re-qualification takes a full 2 ticks.
